// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 mouse receiver.
//   rx_state_e      : byte-level deserializer states
//   FRAME_DATA_BITS : data bits per PS/2 frame
//   SYNC_BIT_IDX    : bit that is always 1 in a mouse status byte
//   PKT_LEN         : bytes per mouse movement packet
//   odd_parity_ok() : 1 when data plus parity bit hold an odd number of ones
package ps2_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } rx_state_e;

  localparam int unsigned FRAME_DATA_BITS = 8;
  localparam int unsigned SYNC_BIT_IDX    = 3;
  localparam int unsigned PKT_LEN         = 3;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_mouse_rx_if.sv
// Bus between the PS/2 mouse receiver and its surroundings.
//   PS2_CLK, PS2_DAT : raw PS/2 lines from the mouse (asynchronous)
//   pkt_en           : 1 enables 3-byte packet assembly
//   rx_byte/rx_valid : every good byte, with a one-cycle strobe
//   byte1..byte3     : last complete mouse packet
//   packet_valid     : one-cycle strobe when byte1..byte3 update
//   frame_err        : one-cycle strobe on parity/stop error or mid-frame timeout
// Modports: master drives the PS/2 lines and pkt_en, slave is the receiver.
interface ps2_mouse_rx_if;

  logic       PS2_CLK;
  logic       PS2_DAT;
  logic       pkt_en;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] byte1;
  logic [7:0] byte2;
  logic [7:0] byte3;
  logic       packet_valid;
  logic       frame_err;

  modport master (
    output PS2_CLK, PS2_DAT, pkt_en,
    input  rx_byte, rx_valid, byte1, byte2, byte3, packet_valid, frame_err
  );

  modport slave (
    input  PS2_CLK, PS2_DAT, pkt_en,
    output rx_byte, rx_valid, byte1, byte2, byte3, packet_valid, frame_err
  );

endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a run-length glitch filter for one PS/2 line.
// The filtered output only takes a new value after FILTER_LEN consecutive
// synchronized samples agree on it. Everything resets to 1 (idle bus level).
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   raw   : raw, asynchronous line
//   filt  : synchronized and filtered line
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt
);

  localparam int unsigned CntW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(FILTER_LEN - 1);

  logic [1:0]      sync_q;
  logic            filt_q;
  logic [CntW-1:0] cnt_q;

  // cnt_q counts consecutive synchronized samples that disagree with filt_q;
  // the FILTER_LEN-th disagreeing sample flips the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], raw};
      if (sync_q[1] == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntLast) begin
        filt_q <= sync_q[1];
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign filt = filt_q;

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 device-to-host receiver and 3-byte mouse packet framer.
// Deserializes 11-bit frames (start, 8 data LSB first, odd parity, stop) from
// filtered PS/2 lines, reports every good byte, and assembles mouse packets
// that resync on the always-one bit of the status byte.
//   Clk     : system clock
//   Reset_n : asynchronous active-low reset
//   bus     : ps2_mouse_rx_if slave (raw lines, pkt_en, byte/packet outputs)
module ps2_mouse_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input logic           Clk,
  input logic           Reset_n,
  ps2_mouse_rx_if.slave bus
);

  localparam int unsigned ToW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ToW-1:0] ToMax = ToW'(TIMEOUT_CYCLES - 1);
  localparam int unsigned BitCntW = $clog2(FRAME_DATA_BITS);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(FRAME_DATA_BITS - 1);
  localparam logic [1:0] LastIdx = 2'(PKT_LEN - 1);

  logic clk_filt;
  logic dat_filt;
  logic clk_filt_prev_q;
  logic clk_fall;
  logic timeout;

  rx_state_e            state_q;
  logic [BitCntW-1:0]   bit_cnt_q;
  logic [7:0]           shift_q;
  logic                 parity_ok_q;
  logic [ToW-1:0]       idle_cnt_q;
  logic [1:0]           pkt_idx_q;
  logic [7:0]           held0_q;
  logic [7:0]           held1_q;

  logic [7:0] rx_byte_q;
  logic       rx_valid_q;
  logic [7:0] byte1_q;
  logic [7:0] byte2_q;
  logic [7:0] byte3_q;
  logic       packet_valid_q;
  logic       frame_err_q;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk   (Clk),
    .rst_n (Reset_n),
    .raw   (bus.PS2_CLK),
    .filt  (clk_filt)
  );

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_dat_filter (
    .clk   (Clk),
    .rst_n (Reset_n),
    .raw   (bus.PS2_DAT),
    .filt  (dat_filt)
  );

  // Both terms are flops, so the fall strobe is glitch-free and lasts exactly
  // the one cycle after the filtered clock drops.
  assign clk_fall = clk_filt_prev_q & ~clk_filt;

  // A fall in the same cycle wins over the timeout; otherwise a start bit
  // arriving after a long idle period would be swallowed.
  assign timeout = ~clk_fall & (idle_cnt_q == ToMax);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clk_filt_prev_q <= 1'b1;
      state_q         <= StIdle;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      parity_ok_q     <= 1'b0;
      idle_cnt_q      <= '0;
      pkt_idx_q       <= '0;
      held0_q         <= '0;
      held1_q         <= '0;
      rx_byte_q       <= '0;
      rx_valid_q      <= 1'b0;
      byte1_q         <= '0;
      byte2_q         <= '0;
      byte3_q         <= '0;
      packet_valid_q  <= 1'b0;
      frame_err_q     <= 1'b0;
    end else begin
      clk_filt_prev_q <= clk_filt;
      rx_valid_q      <= 1'b0;
      packet_valid_q  <= 1'b0;
      frame_err_q     <= 1'b0;

      if (clk_fall) begin
        idle_cnt_q <= '0;
      end else if (idle_cnt_q != ToMax) begin
        idle_cnt_q <= idle_cnt_q + 1'b1;
      end

      if (timeout) begin
        // Idle-line timeouts are silent; only an abandoned frame is an error.
        frame_err_q <= (state_q != StIdle);
        state_q     <= StIdle;
        pkt_idx_q   <= '0;
      end else if (clk_fall) begin
        unique case (state_q)
          StIdle: begin
            // A fall with data high is not a start bit; ignore it.
            if (!dat_filt) begin
              state_q   <= StData;
              bit_cnt_q <= '0;
            end
          end
          StData: begin
            shift_q <= {dat_filt, shift_q[7:1]};
            if (bit_cnt_q == LastBit) begin
              state_q <= StParity;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
          StParity: begin
            parity_ok_q <= odd_parity_ok(shift_q, dat_filt);
            state_q     <= StStop;
          end
          StStop: begin
            state_q <= StIdle;
            if (dat_filt && parity_ok_q) begin
              rx_byte_q  <= shift_q;
              rx_valid_q <= 1'b1;
              if (bus.pkt_en) begin
                if (pkt_idx_q == '0) begin
                  // Only a byte with the sync bit set can open a packet.
                  if (shift_q[SYNC_BIT_IDX]) begin
                    held0_q   <= shift_q;
                    pkt_idx_q <= 2'd1;
                  end
                end else if (pkt_idx_q == LastIdx) begin
                  byte1_q        <= held0_q;
                  byte2_q        <= held1_q;
                  byte3_q        <= shift_q;
                  packet_valid_q <= 1'b1;
                  pkt_idx_q      <= '0;
                end else begin
                  held1_q   <= shift_q;
                  pkt_idx_q <= pkt_idx_q + 1'b1;
                end
              end
            end else begin
              frame_err_q <= 1'b1;
              pkt_idx_q   <= '0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end

      // Packet assembly is disabled; the byte FSM keeps running.
      if (!bus.pkt_en) begin
        pkt_idx_q <= '0;
      end
    end
  end

  assign bus.rx_byte      = rx_byte_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.byte1        = byte1_q;
  assign bus.byte2        = byte2_q;
  assign bus.byte3        = byte3_q;
  assign bus.packet_valid = packet_valid_q;
  assign bus.frame_err    = frame_err_q;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
module tb_ps2_mouse_rx;

  localparam int unsigned FL        = 8;
  localparam int unsigned TO        = 1000;
  localparam int unsigned HALF      = 40;
  localparam int unsigned SHORT_GAP = 100;
  localparam int unsigned LONG_GAP  = 1300;

  logic clk;
  logic rst_n;

  ps2_mouse_rx_if bus ();

  ps2_mouse_rx #(
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Output monitor: records every strobe with the cycle it was seen in.
  int         cyc = 0;
  int         last_fall_cyc = 0;
  int         err_seen = 0;
  logic [7:0] rx_q[$];
  logic [23:0] pkt_q[$];
  int         pkt_cyc_q[$];

  always @(posedge clk) begin
    cyc++;
    #1;
    if (bus.rx_valid) rx_q.push_back(bus.rx_byte);
    if (bus.packet_valid) begin
      pkt_q.push_back({bus.byte1, bus.byte2, bus.byte3});
      pkt_cyc_q.push_back(cyc);
    end
    if (bus.frame_err) err_seen++;
  end

  // Reference model: byte-level view of the mouse protocol.
  logic [7:0] m_held[$];
  logic [7:0] m_b1 = '0, m_b2 = '0, m_b3 = '0, m_rx = '0;
  int         exp_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input bit good, input bit en,
                             input bit long_gap, output int n_rx, output int n_pkt);
    n_rx  = 0;
    n_pkt = 0;
    if (long_gap || !en) m_held.delete();
    if (!good) begin
      exp_err++;
      m_held.delete();
      return;
    end
    n_rx = 1;
    m_rx = b;
    if (en) begin
      if (m_held.size() != 0 || b[3]) m_held.push_back(b);
      if (m_held.size() == 3) begin
        m_b1 = m_held[0];
        m_b2 = m_held[1];
        m_b3 = m_held[2];
        m_held.delete();
        n_pkt = 1;
      end
    end
  endtask

  task automatic flush_mon();
    rx_q.delete();
    pkt_q.delete();
    pkt_cyc_q.delete();
  endtask

  task automatic compare_all(input int n_rx, input int n_pkt);
    check_eq("rx_count", rx_q.size(), n_rx);
    if (n_rx == 1 && rx_q.size() > 0) check_eq("rx_byte_pulse", rx_q[0], m_rx);
    check_eq("pkt_count", pkt_q.size(), n_pkt);
    if (n_pkt == 1 && pkt_q.size() > 0) begin
      check_eq("pkt_bytes", pkt_q[0], {m_b1, m_b2, m_b3});
      check_eq("pkt_latency", pkt_cyc_q[0] - last_fall_cyc, FL + 3);
    end
    check_eq("err_count", err_seen, exp_err);
    check_eq("pkt_hold", {bus.byte1, bus.byte2, bus.byte3}, {m_b1, m_b2, m_b3});
    check_eq("rx_byte_hold", bus.rx_byte, m_rx);
    flush_mon();
  endtask

  // Drives the first nfalls bits of a frame; raw clock falls on a negedge.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nfalls);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nfalls; i++) begin
      @(negedge clk);
      bus.PS2_DAT = bits[i];
      repeat (HALF) @(negedge clk);
      bus.PS2_CLK   = 1'b0;
      last_fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      bus.PS2_CLK = 1'b1;
    end
    bus.PS2_DAT = 1'b1;
  endtask

  task automatic run_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                           input bit en, input bit long_gap);
    int n_rx, n_pkt;
    @(negedge clk);
    bus.pkt_en = en;
    repeat (long_gap ? LONG_GAP : SHORT_GAP) @(negedge clk);
    send_frame(b, bad_par, bad_stop, 11);
    repeat (FL + 10) @(negedge clk);
    model_frame(b, !(bad_par || bad_stop), en, long_gap, n_rx, n_pkt);
    compare_all(n_rx, n_pkt);
  endtask

  initial begin
    logic [7:0] rb;
    bit bp, bs, en, lg;

    bus.PS2_CLK = 1'b1;
    bus.PS2_DAT = 1'b1;
    bus.pkt_en  = 1'b1;
    rst_n       = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("rst_rx_byte", bus.rx_byte, 0);
    check_eq("rst_rx_valid", bus.rx_valid, 0);
    check_eq("rst_bytes", {bus.byte1, bus.byte2, bus.byte3}, 0);
    check_eq("rst_packet_valid", bus.packet_valid, 0);
    check_eq("rst_frame_err", bus.frame_err, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Basic packet.
    run_frame(8'h09, 0, 0, 1, 0);
    run_frame(8'h05, 0, 0, 1, 0);
    run_frame(8'hFB, 0, 0, 1, 0);

    // Parity error, then a clean packet.
    run_frame(8'h09, 1, 0, 1, 0);
    run_frame(8'h0C, 0, 0, 1, 0);
    run_frame(8'h21, 0, 0, 1, 0);
    run_frame(8'h7E, 0, 0, 1, 0);

    // Resync: first byte lacks the sync bit.
    run_frame(8'h05, 0, 0, 1, 0);
    run_frame(8'h09, 0, 0, 1, 0);
    run_frame(8'h05, 0, 0, 1, 0);
    run_frame(8'hFB, 0, 0, 1, 0);

    // Abandoned frame: timeout error, then normal reception.
    @(negedge clk);
    repeat (SHORT_GAP) @(negedge clk);
    send_frame(8'h09, 0, 0, 5);
    repeat (TO + 100) @(negedge clk);
    exp_err++;
    m_held.delete();
    compare_all(0, 0);
    run_frame(8'h18, 0, 0, 1, 0);
    run_frame(8'h33, 0, 0, 1, 0);
    run_frame(8'h44, 0, 0, 1, 0);

    // Byte-only mode.
    run_frame(8'hFA, 0, 0, 0, 0);

    // Short glitches on the clock line between packet bytes.
    run_frame(8'h29, 0, 0, 1, 0);
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      bus.PS2_CLK = 1'b0;
      repeat (3) @(negedge clk);
      bus.PS2_CLK = 1'b1;
      repeat (5) @(negedge clk);
    end
    compare_all(0, 0);
    run_frame(8'h55, 0, 0, 1, 0);
    run_frame(8'hAA, 0, 0, 1, 0);

    // Randomized traffic.
    for (int n = 0; n < 30; n++) begin
      rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) rb[3] = 1'b1;
      bp = ($urandom_range(0, 9) == 0);
      bs = ($urandom_range(0, 19) == 0);
      en = ($urandom_range(0, 6) != 0);
      lg = ($urandom_range(0, 9) == 0);
      run_frame(rb, bp, bs, en, lg);
    end

    // Reset in the middle of a packet.
    run_frame(8'h09, 0, 0, 1, 0);
    repeat (SHORT_GAP) @(negedge clk);
    send_frame(8'h05, 0, 0, 5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_rx_byte", bus.rx_byte, 0);
    check_eq("mid_rst_rx_valid", bus.rx_valid, 0);
    check_eq("mid_rst_byte1", bus.byte1, 0);
    check_eq("mid_rst_byte2", bus.byte2, 0);
    check_eq("mid_rst_byte3", bus.byte3, 0);
    check_eq("mid_rst_packet_valid", bus.packet_valid, 0);
    check_eq("mid_rst_frame_err", bus.frame_err, 0);
    bus.PS2_CLK = 1'b1;
    bus.PS2_DAT = 1'b1;
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    m_held.delete();
    m_b1 = '0;
    m_b2 = '0;
    m_b3 = '0;
    m_rx = '0;
    flush_mon();
    run_frame(8'h0A, 0, 0, 1, 0);
    run_frame(8'h12, 0, 0, 1, 0);
    run_frame(8'h34, 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
